parking_gate_arbiter: RTL and testbench

//  Shares the single barrier gate of the parking system between the entrance lane and the exit lane.

---
 rtl/parking_pkg.sv | 25 ++
 rtl/parking_gate_timer.sv | 37 +++
 rtl/parking_gate_arbiter.sv | 167 ++++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking gate arbiter and the parking system.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OPEN_ENTRY = 2'd1,
    OPEN_EXIT  = 2'd2,
    CLOSE      = 2'd3
  } gate_state_t;

  typedef enum logic {
    LANE_ENTRY = 1'b0,
    LANE_EXIT  = 1'b1
  } lane_t;

  localparam int DEF_CAPACITY     = 8;
  localparam int DEF_CNT_W        = 4;
  localparam int DEF_OPEN_CYCLES  = 16;
  localparam int DEF_CLOSE_CYCLES = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parking_gate_timer.sv
// Up-counter with synchronous clear and a terminal-count flag; shared by the OPEN and CLOSE phases.
module parking_gate_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == term);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Arbitrates the single barrier gate between entrance and exit lanes, tracks lot occupancy
// and refuses authorised entries while the lot is full. All outputs are registered.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             entry_auth,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             reject_entry,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output gate_state_t      dbg_state
);

  localparam int TMR_W = $clog2(max_int(max_int(OPEN_CYCLES, CLOSE_CYCLES), 2));

  // Handshake: a lane is served while its grant is high; the grant ends on car_passed
  // (one-cycle pulse, sampled only while the gate is open) or on the open timeout.

  gate_state_t      state_q, state_d;
  lane_t            last_q, last_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             gate_open_q, gate_open_d;
  logic             grant_entry_q, grant_entry_d;
  logic             grant_exit_q, grant_exit_d;
  logic             reject_q, reject_d;
  logic             armed_q, armed_d;
  logic             rst_hold_q;

  logic             tmr_clear, tmr_en, tmr_tc;
  logic [TMR_W-1:0] tmr_term, tmr_count;
  logic             entry_elig, exit_elig, entry_refused;

  assign tmr_term = (state_q == CLOSE) ? TMR_W'(CLOSE_CYCLES - 1) : TMR_W'(OPEN_CYCLES - 1);

  parking_gate_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clear),
    .en    (tmr_en),
    .term  (tmr_term),
    .count (tmr_count),
    .tc    (tmr_tc)
  );

  assign entry_elig    = entry_req & entry_auth & ~full_q;
  assign exit_elig     = exit_req & ~empty_q;
  assign entry_refused = entry_req & entry_auth & full_q & armed_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    occ_d     = occ_q;
    reject_d  = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    // A refusal re-arms only once the entrant leaves the sensor.
    armed_d   = entry_req ? armed_q : 1'b1;

    if (!rst_hold_q) begin
      unique case (state_q)
        IDLE: begin
          tmr_clear = 1'b1;
          if (entry_refused) begin
            reject_d = 1'b1;
            armed_d  = 1'b0;
          end
          if (entry_elig && exit_elig) begin
            if (last_q == LANE_ENTRY) begin
              state_d = OPEN_EXIT;
              last_d  = LANE_EXIT;
            end else begin
              state_d = OPEN_ENTRY;
              last_d  = LANE_ENTRY;
            end
          end else if (entry_elig) begin
            state_d = OPEN_ENTRY;
            last_d  = LANE_ENTRY;
          end else if (exit_elig) begin
            state_d = OPEN_EXIT;
            last_d  = LANE_EXIT;
          end
        end
        OPEN_ENTRY, OPEN_EXIT: begin
          if (car_passed) begin
            occ_d     = (state_q == OPEN_ENTRY) ? occ_q + 1'b1 : occ_q - 1'b1;
            state_d   = CLOSE;
            tmr_clear = 1'b1;
          end else if (tmr_tc) begin
            state_d   = CLOSE;
            tmr_clear = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        CLOSE: begin
          if (tmr_tc) begin
            state_d   = IDLE;
            tmr_clear = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    gate_open_d   = (state_d == OPEN_ENTRY) || (state_d == OPEN_EXIT);
    grant_entry_d = (state_d == OPEN_ENTRY);
    grant_exit_d  = (state_d == OPEN_EXIT);
    full_d        = (occ_d == CNT_W'(CAPACITY));
    empty_d       = (occ_d == '0);
  end

  // rst_hold_q gives a synchronous release: the first edge after reset only drops the hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_hold_q    <= 1'b1;
      state_q       <= IDLE;
      last_q        <= LANE_ENTRY;
      occ_q         <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      gate_open_q   <= 1'b0;
      grant_entry_q <= 1'b0;
      grant_exit_q  <= 1'b0;
      reject_q      <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      rst_hold_q    <= 1'b0;
      state_q       <= state_d;
      last_q        <= last_d;
      occ_q         <= occ_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      gate_open_q   <= gate_open_d;
      grant_entry_q <= grant_entry_d;
      grant_exit_q  <= grant_exit_d;
      reject_q      <= reject_d;
      armed_q       <= armed_d;
    end
  end

  assign gate_open    = gate_open_q;
  assign grant_entry  = grant_entry_q;
  assign grant_exit   = grant_exit_q;
  assign reject_entry = reject_q;
  assign occupancy    = occ_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Randomized bench for parking_gate_arbiter checked cycle by cycle against a lot-level reference model.
module tb_parking_gate_arbiter;
  import parking_pkg::*;

  localparam int CAP   = 8;
  localparam int OPENC = 16;
  localparam int CLOSC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_req = 1'b0, entry_auth = 1'b0, exit_req = 1'b0, car_passed = 1'b0;
  logic       gate_open, grant_entry, grant_exit, reject_entry, full, empty;
  logic [3:0] occupancy;
  gate_state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: who holds the gate, how long, and how many cars are inside
  int m_owner;    // 0 nobody, 1 entrance, 2 exit
  bit m_closing;
  int m_elapsed;
  int m_occ;
  bit m_last_exit;
  bit m_armed;
  bit m_hold;
  bit m_reject;

  parking_gate_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .entry_req    (entry_req),
    .entry_auth   (entry_auth),
    .exit_req     (exit_req),
    .car_passed   (car_passed),
    .gate_open    (gate_open),
    .grant_entry  (grant_entry),
    .grant_exit   (grant_exit),
    .reject_entry (reject_entry),
    .occupancy    (occupancy),
    .full         (full),
    .empty        (empty),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_closing = 0; m_elapsed = 0; m_occ = 0;
    m_last_exit = 0; m_armed = 1; m_hold = 1; m_reject = 0;
  endtask

  task automatic model_step();
    bit ent_ok, ex_ok;
    m_reject = 0;
    if (!entry_req) m_armed = 1;
    if (m_hold) begin
      m_hold = 0;
    end else if (m_closing) begin
      m_elapsed++;
      if (m_elapsed == CLOSC) m_closing = 0;
    end else if (m_owner != 0) begin
      m_elapsed++;
      if (car_passed) begin
        m_occ = (m_owner == 1) ? m_occ + 1 : m_occ - 1;
        m_owner = 0; m_closing = 1; m_elapsed = 0;
      end else if (m_elapsed == OPENC) begin
        m_owner = 0; m_closing = 1; m_elapsed = 0;
      end
    end else begin
      ent_ok = entry_req && entry_auth && (m_occ < CAP);
      ex_ok  = exit_req && (m_occ > 0);
      if (entry_req && entry_auth && m_occ == CAP && m_armed) begin
        m_reject = 1;
        m_armed = 0;
      end
      if (ent_ok && ex_ok) m_owner = m_last_exit ? 1 : 2;
      else if (ent_ok)     m_owner = 1;
      else if (ex_ok)      m_owner = 2;
      if (m_owner != 0) begin
        m_last_exit = (m_owner == 2);
        m_elapsed = 0;
      end
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".gate_open"},   32'(gate_open),    32'(m_owner != 0));
    check({ph, ".grant_entry"}, 32'(grant_entry),  32'(m_owner == 1));
    check({ph, ".grant_exit"},  32'(grant_exit),   32'(m_owner == 2));
    check({ph, ".reject"},      32'(reject_entry), 32'(m_reject));
    check({ph, ".occupancy"},   32'(occupancy),    32'(m_occ));
    check({ph, ".full"},        32'(full),         32'(m_occ == CAP));
    check({ph, ".empty"},       32'(empty),        32'(m_occ == 0));
  endtask

  task automatic do_cycle(input string ph, input int p_er, input int p_au, input int p_ex, input int p_cp);
    @(negedge clk);
    entry_req  = ($urandom_range(99) < p_er);
    entry_auth = ($urandom_range(99) < p_au);
    exit_req   = ($urandom_range(99) < p_ex);
    car_passed = ($urandom_range(99) < p_cp);
    @(posedge clk);
    model_step();
    #1;
    compare_all(ph);
  endtask

  // assert reset away from the clock edge and confirm the outputs drop without waiting for one
  task automatic do_reset(input string ph);
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
    #1;
    compare_all({ph, ".async"});
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    // steady entrant: gate opens on the second edge after release
    for (int i = 0; i < 60; i++) do_cycle("enter", 100, 100, 0, 20);
    // mixed traffic with prompt passages
    for (int i = 0; i < 1500; i++) do_cycle("mixed", 60, 70, 50, 40);
    // entry-heavy: drives the lot to full and exercises refusals
    for (int i = 0; i < 1500; i++) do_cycle("fill", 92, 95, 8, 60);
    // nobody passes: every grant must time out
    for (int i = 0; i < 600; i++) do_cycle("balk", 70, 70, 50, 0);
    // exit-heavy: drains the lot, then stray passages with an empty lot
    for (int i = 0; i < 1500; i++) do_cycle("drain", 10, 50, 95, 50);
    for (int i = 0; i < 300; i++) do_cycle("empty", 0, 0, 100, 50);
    // refill, then hold an exit grant open and reset in the middle of it
    for (int i = 0; i < 800; i++) do_cycle("refill", 95, 95, 0, 60);
    guard = 0;
    while (!(m_owner == 2 && m_occ > 0) && guard < 200) begin
      do_cycle("exit_wait", 0, 0, 100, 0);
      guard++;
    end
    check("reached_open_exit", 32'(guard < 200), 32'd1);
    do_reset("mid_open");
    for (int i = 0; i < 1500; i++) do_cycle("post_rst", 60, 80, 60, 35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
